// File: rtl/universal_reg_if.sv
// Bundle of operation-select inputs and register outputs for universal_reg.
// The master drives controls and data; the slave returns the register state.
interface universal_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             sout;
    logic             wrap;

    modport master (
        output en, mode, d, sin,
        input  q, nq, sout, wrap
    );

    modport slave (
        input  en, mode, d, sin,
        output q, nq, sout, wrap
    );
endinterface

// File: rtl/universal_reg.sv
// Edge-triggered WIDTH-bit register with hold/load/shift/rotate/count modes,
// complementary output, registered serial-out and a one-cycle count-wrap pulse.
module universal_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [31:0]     RESET_VAL = 32'd0
) (
    input  logic      clk,
    input  logic      rst,
    universal_reg_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             sout_r;
    logic             wrap_r;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(bus.mode);

    // wrap defaults low every edge so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= RESET_Q;
            sout_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (bus.en) begin
                case (mode_sel)
                    MODE_HOLD: q_r <= q_r;
                    MODE_LOAD: q_r <= bus.d;
                    MODE_SHR: begin
                        q_r    <= {bus.sin, q_r[WIDTH-1:1]};
                        sout_r <= q_r[0];
                    end
                    MODE_SHL: begin
                        q_r    <= {q_r[WIDTH-2:0], bus.sin};
                        sout_r <= q_r[WIDTH-1];
                    end
                    MODE_ROR: begin
                        q_r    <= {q_r[0], q_r[WIDTH-1:1]};
                        sout_r <= q_r[0];
                    end
                    MODE_ROL: begin
                        q_r    <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                        sout_r <= q_r[WIDTH-1];
                    end
                    MODE_INC: begin
                        q_r    <= q_r + ONE;
                        wrap_r <= &q_r;
                    end
                    MODE_DEC: begin
                        q_r    <= q_r - ONE;
                        wrap_r <= ~|q_r;
                    end
                    default: q_r <= q_r;
                endcase
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.nq   = ~q_r;
    assign bus.sout = sout_r;
    assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_universal_reg.sv
// Directed plus random bench for universal_reg (WIDTH=8, RESET_VAL=8'hA5);
// a reference model pushes expected state per edge and outputs are compared after it.
module tb_universal_reg;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHR = 3'b010, SHL = 3'b011,
                           ROR  = 3'b100, ROL  = 3'b101, INC = 3'b110, DEC = 3'b111;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    logic [7:0] m_q;
    logic       m_sout;
    logic       m_wrap;

    universal_reg_if #(.WIDTH(8)) bus ();

    universal_reg #(.WIDTH(8), .RESET_VAL(32'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                              input logic [7:0] dv, input logic s);
        if (r) begin
            m_q = 8'hA5; m_sout = 1'b0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (e) begin
                case (m)
                    LOAD: m_q = dv;
                    SHR: begin m_sout = m_q[0]; m_q = {s, m_q[7:1]}; end
                    SHL: begin m_sout = m_q[7]; m_q = {m_q[6:0], s}; end
                    ROR: begin m_sout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
                    ROL: begin m_sout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
                    INC: begin m_wrap = (m_q == 8'hFF); m_q = m_q + 8'd1; end
                    DEC: begin m_wrap = (m_q == 8'h00); m_q = m_q - 8'd1; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] dv, input logic s);
        exp_t ex;
        rst = r; bus.en = e; bus.mode = m; bus.d = dv; bus.sin = s;
        model_step(r, e, m, dv, s);
        ex.q = m_q; ex.sout = m_sout; ex.wrap = m_wrap;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        check({tag, ".q"},    bus.q,           ex.q);
        check({tag, ".nq"},   bus.nq,          ~ex.q);
        check({tag, ".sout"}, {7'd0, bus.sout}, {7'd0, ex.sout});
        check({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, ex.wrap});
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b1; bus.mode = LOAD; bus.d = 8'hFF; bus.sin = 1'b0;
        m_q = 8'h00; m_sout = 1'b0; m_wrap = 1'b0;

        // Reset dominates an enabled LOAD.
        cycle("rst0", 1, 1, LOAD, 8'hFF, 0);
        cycle("rst1", 1, 1, LOAD, 8'hFF, 0);
        check("rst_q_const", bus.q, 8'hA5);
        check("rst_nq_const", bus.nq, 8'h5A);

        // Load, hold, and enable-low with INC selected.
        cycle("load3c", 0, 1, LOAD, 8'h3C, 0);
        for (int i = 0; i < 3; i++) cycle("hold", 0, 1, HOLD, 8'hFF, 1);
        for (int i = 0; i < 2; i++) cycle("en0", 0, 0, INC, 8'hFF, 1);
        check("hold_q_const", bus.q, 8'h3C);
        check("hold_nq_const", bus.nq, 8'hC3);

        // Shifts and rotate-left.
        cycle("load81", 0, 1, LOAD, 8'h81, 0);
        cycle("shr", 0, 1, SHR, 8'h00, 0);
        check("shr_q_const", bus.q, 8'h40);
        cycle("shl", 0, 1, SHL, 8'h00, 1);
        check("shl_q_const", bus.q, 8'h81);
        cycle("rol", 0, 1, ROL, 8'h00, 0);
        check("rol_q_const", bus.q, 8'h03);
        check("rol_sout_const", {7'd0, bus.sout}, 8'h01);

        // Full rotate-right cycle returns to the start value.
        cycle("load01", 0, 1, LOAD, 8'h01, 0);
        for (int i = 0; i < 8; i++) cycle("ror", 0, 1, ROR, 8'h00, 0);
        check("ror_full_const", bus.q, 8'h01);

        // Count wrap in both directions.
        cycle("loadfe", 0, 1, LOAD, 8'hFE, 0);
        cycle("inc_ff", 0, 1, INC, 8'h00, 0);
        cycle("inc_00", 0, 1, INC, 8'h00, 0);
        check("inc_wrap_const", {7'd0, bus.wrap}, 8'h01);
        cycle("dec_ff", 0, 1, DEC, 8'h00, 0);
        check("dec_wrap_const", {7'd0, bus.wrap}, 8'h01);
        cycle("hold_w", 0, 1, HOLD, 8'h00, 0);
        cycle("dec_fe", 0, 1, DEC, 8'h00, 0);
        cycle("en0_w", 0, 0, DEC, 8'h00, 0);

        // Reset mid-count discards the increment.
        cycle("load10", 0, 1, LOAD, 8'h10, 0);
        cycle("inc11", 0, 1, INC, 8'h00, 0);
        cycle("inc12", 0, 1, INC, 8'h00, 0);
        cycle("rst_mid", 1, 1, INC, 8'h00, 0);
        check("rst_mid_const", bus.q, 8'hA5);
        cycle("inc_a6", 0, 1, INC, 8'h00, 0);
        check("post_rst_const", bus.q, 8'hA6);

        // Random mix, including enable toggling and occasional reset.
        for (int i = 0; i < 300; i++) begin
            cycle("rand",
                  ($urandom_range(0, 31) == 0),
                  logic'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)),
                  logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
